// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// small receive FIFO and a single status/data word with one-cycle ready.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  input  logic        rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, rx_s;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             overrun, frame_err;

  logic             sample, push, ferr_set, empty, full;
  logic             accept, is_read, pop, push_ok;
  logic [31:0]      status;
  logic             unused_bus;

  assign unused_bus = ^{uart_instr, uart_addr, uart_wdata};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        // Re-check the start bit at its middle so short glitches are dropped.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sample   = (cnt == BIT_LAST);
  assign push     = (state == STOP) && sample && rx_s;
  assign ferr_set = (state == STOP) && sample && !rx_s;

  always_ff @(posedge clock) begin
    if (state == DATA && sample) shift <= {rx_s, shift[7:1]};
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign accept  = uart_valid && !uart_ready;
  assign is_read = accept && (uart_wstrb == 4'h0);
  assign pop     = is_read && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still takes the byte.
  assign push_ok = push && (!full || pop);

  always_comb begin
    status = {21'b0, frame_err, overrun, !empty, 8'h00};
    if (!empty) status[7:0] = mem[rd_ptr[PTR_W-1:0]];
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_ready <= 1'b0;
      uart_rdata <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      uart_ready <= accept;
      uart_rdata <= is_read ? status : 32'h0;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (push && !push_ok) overrun <= 1'b1;
      else if (is_read)     overrun <= 1'b0;
      if (ferr_set)         frame_err <= 1'b1;
      else if (is_read)     frame_err <= 1'b0;
    end
  end

endmodule
